// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. A single full-adder cell adds two WIDTH-bit operands one
// bit per clock, LSB first. The carry between bits is kept in a register.
// Operands are captured into shift registers on an accepted start. The result
// is assembled in an internal shift register. It is copied to the sum/cout
// outputs only on the completion edge, so those outputs never show a partial
// result.
//
// Sequence: IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
// The start input is sampled only in IDLE.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request an addition (sampled only in IDLE)
//   a, b   in   operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  registered result, updated only at completion
//   cout   out  registered carry-out of bit WIDTH-1
//   ovf    out  (only with SERIAL_ADDER_OVF_EN) two's-complement overflow,
//               registered together with sum/cout
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf output.
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // The single full-adder cell, fed from the LSBs of the operand shifters.
  logic fs, fc, px;
  assign px = a_sh_q[0] ^ b_sh_q[0];
  assign fs = px ^ carry_q;
  assign fc = (a_sh_q[0] & b_sh_q[0]) | (carry_q & px);

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // The result fills from the MSB end. After WIDTH shifts, bit 0 has
        // reached the LSB.
        res_sh_d = {fs, res_sh_q[WIDTH-1:1]};
        carry_d  = fc;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          sum_d   = {fs, res_sh_q[WIDTH-1:1]};
          cout_d  = fc;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB; fc is the carry out of it.
          ovf_d   = carry_q ^ fc;
`endif
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
